// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb, drives datapath
// selects and strobes, counts retired instructions and stops on system, illegal or bus timeout.
module riscv_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        branch_taken_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic [1:0]  mem_size_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o
);

  localparam int unsigned WAIT_W = 16;
  localparam int unsigned CNT_W  = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               halt_q, halt_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               timeout_c;
  logic               unused_funct3;

  // Only the access size bits of funct3 matter to the controller.
  assign unused_funct3 = funct3_i[2];

  assign timeout_c = (wait_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    halt_d         = halt_q;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    mem_size_o     = 2'd0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = 2'd0;
    rf_we_o        = 1'b0;
    wb_sel_o       = 2'd0;
    alu_a_sel_o    = 1'b0;
    alu_b_sel_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_size_o = 2'b10;
        ir_we_o    = mem_ready_i;
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode_i)
          OP_R:   state_d = S_WB;
          OP_IMM: begin
            alu_b_sel_o = 1'b1;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel_o = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            pc_we_o  = 1'b1;
            pc_sel_o = branch_taken_i ? 2'd2 : 2'd0;
            state_d  = S_FETCH;
          end
          OP_JAL: begin
            rf_we_o  = 1'b1;
            wb_sel_o = 2'd2;
            pc_we_o  = 1'b1;
            pc_sel_o = 2'd2;
            state_d  = S_FETCH;
          end
          OP_JALR: begin
            alu_b_sel_o = 1'b1;
            rf_we_o     = 1'b1;
            wb_sel_o    = 2'd2;
            pc_we_o     = 1'b1;
            pc_sel_o    = 2'd1;
            state_d     = S_FETCH;
          end
          OP_LUI: begin
            rf_we_o  = 1'b1;
            wb_sel_o = 2'd3;
            pc_we_o  = 1'b1;
            state_d  = S_FETCH;
          end
          OP_AUIPC: begin
            alu_a_sel_o = 1'b1;
            alu_b_sel_o = 1'b1;
            rf_we_o     = 1'b1;
            pc_we_o     = 1'b1;
            state_d     = S_FETCH;
          end
          OP_SYSTEM: begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        alu_b_sel_o    = 1'b1;
        mem_size_o     = funct3_i[1:0];
        mem_we_o       = (opcode_i == OP_STORE);
        if (mem_ready_i) begin
          if (opcode_i == OP_STORE) begin
            pc_we_o = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        rf_we_o     = 1'b1;
        wb_sel_o    = (opcode_i == OP_LOAD) ? 2'd1 : 2'd0;
        alu_b_sel_o = (opcode_i != OP_R);
        pc_we_o     = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = state_q;
    endcase

    // Wait counter only runs while a memory access is pending in the same state.
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready_i && state_d == state_q) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end

    if (rst_i) begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      mem_size_o     = 2'd0;
      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_sel_o       = 2'd0;
      rf_we_o        = 1'b0;
      wb_sel_o       = 2'd0;
      alu_a_sel_o    = 1'b0;
      alu_b_sel_o    = 1'b0;
    end

    instret_d = instret_q + CNT_W'(pc_we_o);
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign halt_o    = halt_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: doc/riscv_mc_control.md
# riscv_mc_control

Control FSM that sequences the multi-cycle RV32I datapath (instruction decoder, ALU, register file, unified memory port) one instruction at a time. It runs the fetch, decode, execute, memory and write-back phases. It drives every datapath select and write enable, handshakes with memory, counts retired instructions, and stops on system instructions, illegal opcodes or a memory timeout.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles for `mem_ready` before a bus error (1..65535).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  `instr[6:0]` from the decoder; valid from DECODE onward.
- funct3  in  3  `instr[14:12]`; used only for `mem_size`.
- branch_taken  in  1  branch comparator result; valid in EXEC.
- mem_ready  in  1  memory completion, sampled while `mem_req`=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store.
- mem_addr_sel  out  1  0 = pc, 1 = alu result.
- mem_size  out  2  `funct3[1:0]` in MEM; 2'b10 in FETCH.
- ir_we  out  1  latch instruction register.
- pc_we  out  1  update pc.
- pc_sel  out  2  0 = pc+4, 1 = alu result with bit 0 cleared, 2 = pc+imm.
- rf_we  out  1  register file write.
- wb_sel  out  2  0 = alu, 1 = memory data, 2 = pc+4, 3 = imm.
- alu_a_sel  out  1  0 = rs1, 1 = pc.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- halt  out  1  sticky; set on SYSTEM opcode.
- illegal  out  1  sticky; set on unknown opcode.
- bus_err  out  1  sticky; set on memory timeout.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- instret  out  32  retired-instruction count.

## Operation
- **Output encoding.** Outputs are combinational from `state`, `opcode`, `branch_taken` and `mem_ready`. Any output not listed for a state is 0.
- **FETCH.**
  - Drive `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - `ir_we` = `mem_ready`. On `mem_ready`, go to DECODE.
- **DECODE.** Register file read. Go to EXEC unconditionally.
- **EXEC, by opcode:**
  - 0110011 (R): `alu_b_sel`=0. Go to WB.
  - 0010011 (I-ALU): `alu_b_sel`=1. Go to WB.
  - 0000011 (load), 0100011 (store): `alu_b_sel`=1 (address). Go to MEM.
  - 1100011 (branch): `pc_we`=1, `pc_sel` = `branch_taken` ? 2 : 0. Go to FETCH.
  - 1101111 (jal): `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=2. Go to FETCH.
  - 1100111 (jalr): `alu_b_sel`=1, `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=1. Go to FETCH.
  - 0110111 (lui): `rf_we`=1, `wb_sel`=3, `pc_we`=1. Go to FETCH.
  - 0010111 (auipc): `alu_a_sel`=1, `alu_b_sel`=1, `rf_we`=1, `wb_sel`=0, `pc_we`=1. Go to FETCH.
  - 1110011 (system): go to HALT, `halt`←1. No retire.
  - Any other opcode: go to TRAP, `illegal`←1.
- **MEM.**
  - Drive `mem_req`=1, `mem_addr_sel`=1, `alu_b_sel`=1, `mem_we` = (opcode==0100011).
  - Load: on `mem_ready`, go to WB.
  - Store: on `mem_ready`, `pc_we`=1, `pc_sel`=0, go to FETCH.
- **WB.** `rf_we`=1, `wb_sel` = load ? 1 : 0, `alu_b_sel` kept as in EXEC, `pc_we`=1, `pc_sel`=0. Go to FETCH.
- **HALT / TRAP.** Absorbing states: all strobes 0, left only by `rst`.
- **Retire.** `instret` increments by 1 in every cycle where `pc_we`=1. Wraps 0xFFFFFFFF→0.
- **Timeout.** A 16-bit wait counter increments each cycle in FETCH or MEM with `mem_ready`=0, and clears on `mem_ready` or on any state change. When the count equals MEM_TIMEOUT while `mem_ready`=0, go to TRAP and set `bus_err`←1. `mem_ready` in that same cycle wins: the access completes and there is no error.

## Timing
- **Reset.** `rst` high asynchronously sets `state`=FETCH and clears `instret`, the wait counter, `halt`, `illegal` and `bus_err`. While `rst` is high, all outputs are forced to 0. In the first cycle after release, `mem_req`=1.
- **Reset mid-instruction.** Partial work is abandoned; there is no write-back. `rf_we`/`pc_we` are never 1 while `rst`=1.
- **Latency with zero-wait memory** (`mem_ready` high in the first request cycle): R/I-ALU 4, load 5, store 4, branch/jal/jalr/lui/auipc 3 cycles. Each wait cycle adds 1.
- **Memory handshake.** `mem_req` stays high and its address/we/size stay stable until the cycle `mem_ready`=1. `mem_ready` is ignored when `mem_req`=0.
- **Write-enable exclusivity.** At most one `rf_we` and one `pc_we` pulse per instruction, each exactly 1 cycle. `pc_we` and `rf_we` are coincident for jal/jalr/lui/auipc.

## Test plan
- **R-type, zero-wait.** Opcode 0110011 → states 0,1,2,4,0 over 4 cycles. `rf_we`/`pc_we` high only in WB with `pc_sel`=0. `instret` goes 0→1.
- **Load with 3 wait cycles.** Opcode 0000011 → MEM holds `mem_req`=1, `mem_addr_sel`=1 for 4 cycles. WB `wb_sel`=1. Total 8 cycles.
- **Branches.** Opcode 1100011 with `branch_taken`=1 → EXEC `pc_sel`=2. With `branch_taken`=0 → `pc_sel`=0. Both retire in 3 cycles with no `rf_we`.
- **Memory timeout.** MEM_TIMEOUT=4, `mem_ready` stuck 0 in FETCH → TRAP after the 5th FETCH cycle, `bus_err`=1, `instret` unchanged. Repeat with `mem_ready`=1 in the 5th cycle → DECODE, no error.
- **Halt and illegal.** Opcode 1110011 → HALT, `halt`=1, outputs idle for 20 cycles. Opcode 0000000 → TRAP, `illegal`=1. Then pulse `rst` → FETCH, flags cleared.
- **Reset and wrap.** Assert `rst` during MEM of a store → no `mem_we` after the reset edge, `instret`=0. Force `instret`=0xFFFFFFFF and retire one instruction → 0x00000000.
